// File: rtl/stopwatch_pkg.sv
// Shared constants for the lap stopwatch: segment patterns, dash pattern,
// per-digit BCD limits and the m:ss.t time record.
package stopwatch_pkg;

   // Segment patterns in {g,f,e,d,c,b,a} order, active-low.
   localparam logic [6:0] SEG_0    = 7'b1000000;
   localparam logic [6:0] SEG_1    = 7'b1111001;
   localparam logic [6:0] SEG_2    = 7'b0100100;
   localparam logic [6:0] SEG_3    = 7'b0110000;
   localparam logic [6:0] SEG_4    = 7'b0011001;
   localparam logic [6:0] SEG_5    = 7'b0010010;
   localparam logic [6:0] SEG_6    = 7'b0000010;
   localparam logic [6:0] SEG_7    = 7'b1111000;
   localparam logic [6:0] SEG_8    = 7'b0000000;
   localparam logic [6:0] SEG_9    = 7'b0010000;
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_OFF  = 7'b1111111;

   // Highest value each digit reaches before wrapping: tenths, seconds,
   // tens of seconds, minutes.
   localparam logic [3:0] LIMIT_D0 = 4'd9;
   localparam logic [3:0] LIMIT_D1 = 4'd9;
   localparam logic [3:0] LIMIT_D2 = 4'd5;
   localparam logic [3:0] LIMIT_D3 = 4'd9;

   // Displayed time m:ss.t as four BCD digits.
   typedef struct packed {
      logic [3:0] d3;
      logic [3:0] d2;
      logic [3:0] d1;
      logic [3:0] d0;
   } bcd_time_t;

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low seven-segment pattern; anything above 9 shows a dash.
module seg7_decode
   import stopwatch_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   // Pure lookup; outputs {g,f,e,d,c,b,a}.
   always_comb begin
      seg = SEG_DASH;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/lap_stopwatch.sv
// Tenths-resolution stopwatch (m:ss.t) with lap freeze, overflow flash and a
// multiplexed four-digit active-low seven-segment display.
module lap_stopwatch
   import stopwatch_pkg::*;
#(
   parameter int unsigned TICK_DIV     = 5000000,
   parameter int unsigned REFRESH_BITS = 18,
   parameter int unsigned FLASH_TICKS  = 5
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start_stop,
   input  logic       lap,
   input  logic       clear,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       d,
   output logic       e,
   output logic       f,
   output logic       g,
   output logic       dp,
   output logic [3:0] an,
   output logic       running,
   output logic       overflow
);

   localparam int unsigned PresWidth  = $clog2(TICK_DIV);
   localparam int unsigned FlashWidth = $clog2(FLASH_TICKS + 1);

   // Button bit order: {clear, lap, start_stop}.
   logic [2:0] btn_sync1_q, btn_sync2_q, btn_prev_q, btn_pulse_q;
   logic       ss_pulse, lap_pulse, clr_pulse;

   logic [PresWidth-1:0]    presc_q;
   logic                    tick;
   logic [REFRESH_BITS-1:0] scan_q;
   logic [FlashWidth-1:0]   flash_cnt_q;
   logic                    flash_q;

   bcd_time_t  time_q, lap_q, time_inc, shown;
   logic       time_wrap;
   logic       running_q, frozen_q, overflow_q;
   logic [1:0] sel;
   logic [3:0] digit;
   logic [6:0] seg_dec, segs;
   logic       blank;

   // Two-flop synchroniser plus registered rising-edge detect per button.
   always_ff @(posedge clock) begin
      if (reset) begin
         btn_sync1_q <= '0;
         btn_sync2_q <= '0;
         btn_prev_q  <= '0;
         btn_pulse_q <= '0;
      end else begin
         btn_sync1_q <= {clear, lap, start_stop};
         btn_sync2_q <= btn_sync1_q;
         btn_prev_q  <= btn_sync2_q;
         btn_pulse_q <= btn_sync2_q & ~btn_prev_q;
      end
   end

   assign ss_pulse  = btn_pulse_q[0];
   assign lap_pulse = btn_pulse_q[1];
   assign clr_pulse = btn_pulse_q[2];

   assign tick = (presc_q == PresWidth'(TICK_DIV - 1));

   // Free-running prescaler and display scan counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         presc_q <= '0;
         scan_q  <= '0;
      end else begin
         presc_q <= tick ? '0 : presc_q + PresWidth'(1);
         scan_q  <= scan_q + REFRESH_BITS'(1);
      end
   end

   // BCD increment with ripple carry; time_wrap flags 9:59.9 -> 0:00.0.
   always_comb begin
      time_inc  = time_q;
      time_wrap = 1'b0;
      if (time_q.d0 != LIMIT_D0) begin
         time_inc.d0 = time_q.d0 + 4'd1;
      end else begin
         time_inc.d0 = '0;
         if (time_q.d1 != LIMIT_D1) begin
            time_inc.d1 = time_q.d1 + 4'd1;
         end else begin
            time_inc.d1 = '0;
            if (time_q.d2 != LIMIT_D2) begin
               time_inc.d2 = time_q.d2 + 4'd1;
            end else begin
               time_inc.d2 = '0;
               if (time_q.d3 != LIMIT_D3) begin
                  time_inc.d3 = time_q.d3 + 4'd1;
               end else begin
                  time_inc.d3 = '0;
                  time_wrap   = 1'b1;
               end
            end
         end
      end
   end

   // Control and time state; an accepted clear swallows the other pulses.
   always_ff @(posedge clock) begin
      if (reset) begin
         time_q     <= '0;
         lap_q      <= '0;
         frozen_q   <= 1'b0;
         running_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else if (clr_pulse && !running_q) begin
         time_q     <= '0;
         lap_q      <= '0;
         frozen_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         if (ss_pulse) begin
            running_q <= ~running_q;
         end
         // Capture uses time_q, so a coincident tick's increment is excluded.
         if (lap_pulse) begin
            if (!frozen_q) begin
               lap_q    <= time_q;
               frozen_q <= 1'b1;
            end else begin
               frozen_q <= 1'b0;
            end
         end
         if (tick && running_q) begin
            time_q <= time_inc;
            if (time_wrap) begin
               overflow_q <= 1'b1;
            end
         end
      end
   end

   // Overflow flash phase; held at rest while no overflow is pending.
   always_ff @(posedge clock) begin
      if (reset || !overflow_q) begin
         flash_cnt_q <= '0;
         flash_q     <= 1'b0;
      end else if (tick) begin
         if (flash_cnt_q == FlashWidth'(FLASH_TICKS - 1)) begin
            flash_cnt_q <= '0;
            flash_q     <= ~flash_q;
         end else begin
            flash_cnt_q <= flash_cnt_q + FlashWidth'(1);
         end
      end
   end

   assign sel   = scan_q[REFRESH_BITS-1 -: 2];
   assign shown = frozen_q ? lap_q : time_q;

   // Pick the digit for the currently scanned position.
   always_comb begin
      digit = shown.d0;
      unique case (sel)
         2'd0: digit = shown.d0;
         2'd1: digit = shown.d1;
         2'd2: digit = shown.d2;
         2'd3: digit = shown.d3;
      endcase
   end

   seg7_decode u_decode (
      .digit (digit),
      .seg   (seg_dec)
   );

   assign blank = overflow_q & flash_q;
   assign segs  = blank ? SEG_OFF : seg_dec;
   assign {g, f, e, d, c, b, a} = segs;
   // Decimal point lit after seconds (d1) and minutes (d3).
   assign dp       = blank | ~sel[0];
   assign an       = ~(4'b0001 << sel);
   assign running  = running_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Scoreboard bench for lap_stopwatch: a tenths-count reference model queues the
// expected display each cycle; a negedge monitor pops and compares.
module tb_lap_stopwatch;

   localparam int TickDiv    = 4;
   localparam int FlashTicks = 2;
   localparam int RefreshBits = 4;
   localparam int ScanLen    = 1 << RefreshBits;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start_stop = 1'b0;
   logic       lap = 1'b0;
   logic       clear = 1'b0;
   logic       a, b, c, d, e, f, g, dp, running, overflow;
   logic [3:0] an;

   always #5 clock = ~clock;

   lap_stopwatch #(
      .TICK_DIV     (TickDiv),
      .REFRESH_BITS (RefreshBits),
      .FLASH_TICKS  (FlashTicks)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .start_stop (start_stop),
      .lap        (lap),
      .clear      (clear),
      .a          (a),
      .b          (b),
      .c          (c),
      .d          (d),
      .e          (e),
      .f          (f),
      .g          (g),
      .dp         (dp),
      .an         (an),
      .running    (running),
      .overflow   (overflow)
   );

   typedef logic [13:0] obs_t;   // {an, g..a, dp, running, overflow}
   obs_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   logic [6:0] seg_ref [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

   // Reference state: time as total tenths 0..5999.
   int       m_cyc, m_tenths, m_lap, m_ovf_ticks;
   bit       m_run, m_frozen, m_ovf;
   bit [4:0] h_ss, h_lp, h_cl;   // pin samples, [0] = most recent edge

   function automatic int digit_of(int t, int sel);
      case (sel)
         0:       return t % 10;
         1:       return (t / 10) % 10;
         2:       return (t / 100) % 6;
         default: return t / 600;
      endcase
   endfunction

   function automatic obs_t expected();
      int       sel, dig;
      bit       blank;
      logic [3:0] an_e;
      logic [6:0] seg_e;
      logic       dp_e;
      sel   = (m_cyc % ScanLen) / (ScanLen / 4);
      dig   = digit_of(m_frozen ? m_lap : m_tenths, sel);
      blank = m_ovf && (((m_ovf_ticks / FlashTicks) % 2) == 1);
      an_e  = ~(4'b0001 << sel);
      seg_e = blank ? 7'h7f : seg_ref[dig];
      dp_e  = blank ? 1'b1 : ((sel == 1 || sel == 3) ? 1'b0 : 1'b1);
      return {an_e, seg_e, dp_e, m_run, m_ovf};
   endfunction

   // Advance the reference by one clock edge using the pins the DUT sampled.
   task automatic model_edge();
      bit tick, ss_p, lp_p, cl_p;
      if (reset) begin
         m_cyc = 0; m_tenths = 0; m_lap = 0; m_ovf_ticks = 0;
         m_run = 0; m_frozen = 0; m_ovf = 0;
         h_ss = '0; h_lp = '0; h_cl = '0;
         return;
      end
      h_ss = {h_ss[3:0], start_stop};
      h_lp = {h_lp[3:0], lap};
      h_cl = {h_cl[3:0], clear};
      // A press first sampled three edges ago takes effect now.
      ss_p = h_ss[3] && !h_ss[4];
      lp_p = h_lp[3] && !h_lp[4];
      cl_p = h_cl[3] && !h_cl[4];
      tick = (m_cyc % TickDiv) == TickDiv - 1;
      if (m_ovf && tick) m_ovf_ticks++;
      if (cl_p && !m_run) begin
         m_tenths = 0; m_lap = 0; m_frozen = 0; m_ovf = 0; m_ovf_ticks = 0;
      end else begin
         bit was_running = m_run;
         if (ss_p) m_run = !m_run;
         if (lp_p) begin
            if (!m_frozen) begin
               m_lap = m_tenths;
               m_frozen = 1;
            end else begin
               m_frozen = 0;
            end
         end
         if (tick && was_running) begin
            if (m_tenths == 5999) begin
               m_tenths = 0;
               if (!m_ovf) m_ovf_ticks = 0;
               m_ovf = 1;
            end else begin
               m_tenths++;
            end
         end
      end
      m_cyc++;
   endtask

   task automatic cycle();
      @(posedge clock);
      model_edge();
      exp_q.push_back(expected());
      #1;
   endtask

   task automatic cycles(int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // Hold a pin high long enough to pass the synchroniser, then release.
   task automatic press(input int which);
      if (which == 0) start_stop = 1'b1;
      else if (which == 1) lap = 1'b1;
      else clear = 1'b1;
      cycles(4);
      start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
      cycles(4);
   endtask

   task automatic run_until(int target, int budget);
      int n = 0;
      while (m_tenths != target && n < budget) begin
         cycle();
         n++;
      end
      if (m_tenths != target) begin
         miscompares++;
         $display("FAIL run_until: reached %0d, required %0d", m_tenths, target);
      end
   endtask

   // Monitor: compare the display presented after each edge.
   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         obs_t want, got;
         want = exp_q.pop_front();
         got  = {an, g, f, e, d, c, b, a, dp, running, overflow};
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL display t=%0t: an/seg/dp/run/ovf got %b required %b",
                     $time, got, want);
         end
      end
   end

   initial begin
      cycles(3);
      reset = 1'b0;
      cycles(100);                   // idle scan, all zeros

      press(0);                      // start
      cycles(40 * TickDiv);
      press(0);                      // stop
      cycles(20 * TickDiv);

      press(2);                      // clear while stopped
      press(0);                      // start
      run_until(13, 200);
      press(1);                      // freeze
      cycles(10 * TickDiv);
      press(1);                      // unfreeze
      cycles(20);

      run_until(5998, 30000);        // approach wrap
      cycles(20 * TickDiv);          // overflow and flashing

      press(2);                      // ignored while running
      cycles(8);
      press(0);                      // stop
      clear = 1'b1; start_stop = 1'b1;
      cycles(4);
      clear = 1'b0; start_stop = 1'b0;
      cycles(20);

      press(0);
      run_until(37, 600);
      reset = 1'b1;                  // mid-count reset
      cycles(2);
      reset = 1'b0;
      cycles(20);

      // Random button activity with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 19) == 0) start_stop = ~start_stop;
         if ($urandom_range(0, 19) == 0) lap = ~lap;
         if ($urandom_range(0, 29) == 0) clear = ~clear;
         reset = ($urandom_range(0, 499) == 0);
         cycle();
      end
      reset = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
      cycles(10);
      @(negedge clock);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
